// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : RV32I major-opcode decoder feeding the ID/EX, EX/MEM and
//                MEM/WB control pipeline registers. Adds load-use hazard
//                detection (bubble insertion), branch flush and
//                illegal-opcode flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
  parameter int CTRL_WIDTH = 16,  // control bundle width, at least 8
  parameter int RADDR_W    = 5    // register address width
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [6:0]            opcode_i,
  input  logic [RADDR_W-1:0]    rd_i,
  input  logic [RADDR_W-1:0]    rs1_i,
  input  logic [RADDR_W-1:0]    rs2_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  illegal_o,
  output logic [CTRL_WIDTH-1:0] ctrl_ex_o,
  output logic [CTRL_WIDTH-1:0] ctrl_mem_o,
  output logic [CTRL_WIDTH-1:0] ctrl_wb_o,
  output logic                  valid_ex_o,
  output logic                  valid_mem_o,
  output logic                  valid_wb_o,
  output logic [RADDR_W-1:0]    rd_ex_o,
  output logic [RADDR_W-1:0]    rd_mem_o,
  output logic [RADDR_W-1:0]    rd_wb_o
);

  // RV32I major opcodes handled by this decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Low byte of the bundle: {aluop[1:0], alusrc, is_branch, mem_re, mem_we,
  // reg_we, is_mem_to_reg}
  localparam logic [7:0] BUNDLE_R      = 8'b10_1_0_0_0_1_0;
  localparam logic [7:0] BUNDLE_I      = 8'b10_0_0_0_0_1_0;
  localparam logic [7:0] BUNDLE_LOAD   = 8'b00_0_0_1_0_1_1;
  localparam logic [7:0] BUNDLE_STORE  = 8'b00_0_0_0_1_0_0;
  localparam logic [7:0] BUNDLE_BRANCH = 8'b01_1_1_0_0_0_0;

  // Bit position of mem_re inside the bundle
  localparam int MEM_RE_BIT = 3;

  logic [7:0]            dec_byte;
  logic [CTRL_WIDTH-1:0] dec_ctrl;
  logic                  dec_legal;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  hazard_rs1;
  logic                  hazard_rs2;
  logic                  ex_is_load;
  logic                  load_id;
  logic                  illegal_id;

  // Opcode decode: bundle byte, source-register usage and legality
  always_comb begin
    dec_byte  = 8'h00;
    dec_legal = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    case (opcode_i)
      OP_R: begin
        dec_byte  = BUNDLE_R;
        dec_legal = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      OP_I: begin
        dec_byte  = BUNDLE_I;
        dec_legal = 1'b1;
        rs1_used  = 1'b1;
      end
      OP_LOAD: begin
        dec_byte  = BUNDLE_LOAD;
        dec_legal = 1'b1;
        rs1_used  = 1'b1;
      end
      OP_STORE: begin
        dec_byte  = BUNDLE_STORE;
        dec_legal = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      OP_BRANCH: begin
        dec_byte  = BUNDLE_BRANCH;
        dec_legal = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      default: begin
        dec_byte  = 8'h00;
        dec_legal = 1'b0;
      end
    endcase
  end

  // Widen the decoded byte to the bundle width; upper bits are reserved as 0
  always_comb begin
    dec_ctrl      = '0;
    dec_ctrl[7:0] = dec_byte;
  end

  // Load-use hazard: a load in EX whose destination feeds a used ID source.
  // x0 never creates a hazard, and a flush cancels the stall because the
  // dependent instruction is being killed anyway.
  always_comb begin
    ex_is_load = valid_ex_o & ctrl_ex_o[MEM_RE_BIT];
    hazard_rs1 = rs1_used & (rs1_i == rd_ex_o);
    hazard_rs2 = rs2_used & (rs2_i == rd_ex_o);
    stall_o    = valid_i & ex_is_load & (rd_ex_o != '0)
               & (hazard_rs1 | hazard_rs2) & ~flush_i;
  end

  // ID/EX loads the decoded instruction only when nothing turns it into a bubble
  always_comb begin
    load_id    = valid_i & ~flush_i & ~stall_o;
    illegal_id = load_id & ~dec_legal;
  end

  // ID/EX register: decoded bundle, or a bubble on flush, stall or invalid ID
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_ex_o  <= '0;
      valid_ex_o <= 1'b0;
      rd_ex_o    <= '0;
      illegal_o  <= 1'b0;
    end else if (load_id) begin
      ctrl_ex_o  <= dec_ctrl;
      valid_ex_o <= 1'b1;
      rd_ex_o    <= rd_i;
      illegal_o  <= illegal_id;
    end else begin
      ctrl_ex_o  <= '0;
      valid_ex_o <= 1'b0;
      rd_ex_o    <= '0;
      illegal_o  <= 1'b0;
    end
  end

  // EX/MEM register: follows ID/EX, except a flush kills the EX instruction
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_mem_o  <= '0;
      valid_mem_o <= 1'b0;
      rd_mem_o    <= '0;
    end else if (flush_i) begin
      ctrl_mem_o  <= '0;
      valid_mem_o <= 1'b0;
      rd_mem_o    <= '0;
    end else begin
      ctrl_mem_o  <= ctrl_ex_o;
      valid_mem_o <= valid_ex_o;
      rd_mem_o    <= rd_ex_o;
    end
  end

  // MEM/WB register: always advances from EX/MEM
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_wb_o  <= '0;
      valid_wb_o <= 1'b0;
      rd_wb_o    <= '0;
    end else begin
      ctrl_wb_o  <= ctrl_mem_o;
      valid_wb_o <= valid_mem_o;
      rd_wb_o    <= rd_mem_o;
    end
  end

endmodule
`default_nettype wire
